reset_sequencer: RTL and testbench

Parametrised reset sequencer for the FPGA board tops. It replaces the fixed one-per-clock power-on reset generator. It merges three reset sources into one request: the board reset, a debounced active-low pushbutton and a synchronous software request. It drives `NUM_OUTPUTS` active-high reset lines that deassert in staggered order (PLL/memory first, fabric last) and reports readiness and a reset-event count. One instance sits in each clock domain of a board top.

---
 rtl/reset_seq_pkg.sv | 18 +
 rtl/reset_sync.sv | 24 ++
 rtl/reset_sequencer.sv | 145 ++++++++++++++
 tb/tb_reset_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer and its board-top users.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } seq_state_t;

    localparam int EVENT_CNT_W = 8;

    // Width of a counter that must hold 0..max_count; never narrower than 1 bit
    // so a zero-valued parameter still yields a legal vector.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Async-assert / sync-deassert reset synchroniser. The output rises as soon as
// rst rises and falls on the SYNC_STAGES-th clock edge after rst falls.
module reset_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    output logic sync_rst
);

    logic [SYNC_STAGES-1:0] stage_reg;

    // Shift the released level (0) through the chain; rst presets every stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_reg <= '1;
        end else begin
            stage_reg <= {stage_reg[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign sync_rst = stage_reg[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: merges board reset, debounced pushbutton and software
// request, then releases NUM_OUTPUTS reset lines in staggered order
// (bit 0 first) and counts key/software reset events.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_OUTPUTS     = 4,
    parameter int HOLD_CYCLES     = 16,
    parameter int STAGGER_CYCLES  = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   key_n,
    input  logic                   sw_req,
    output logic [NUM_OUTPUTS-1:0] reset_out,
    output logic                   ready,
    output logic [EVENT_CNT_W-1:0] event_count
);

    localparam int HOLD_W    = cnt_width(HOLD_CYCLES);
    localparam int STAG_W    = cnt_width(STAGGER_CYCLES);
    localparam int DEB_W     = cnt_width(DEBOUNCE_CYCLES);
    localparam int HOLD_LAST = HOLD_CYCLES - 1;
    localparam int STAG_LAST = (STAGGER_CYCLES > 0) ? STAGGER_CYCLES - 1 : 0;
    localparam int DEB_LAST  = DEBOUNCE_CYCLES - 1;
    // All bits leave reset together when there is nothing to stagger.
    localparam bit ONE_SHOT  = (NUM_OUTPUTS == 1) || (STAGGER_CYCLES == 0);

    logic                   rst_int;
    logic [SYNC_STAGES-1:0] key_sync_reg;
    logic                   key_deb_reg;
    logic [DEB_W-1:0]       deb_cnt_reg;
    logic                   req_reg;
    seq_state_t             state_reg;
    logic [HOLD_W-1:0]      hold_cnt_reg;
    logic [STAG_W-1:0]      stag_cnt_reg;
    logic [NUM_OUTPUTS-1:0] reset_out_reg;
    logic                   ready_reg;
    logic [EVENT_CNT_W-1:0] event_cnt_reg;
    logic [NUM_OUTPUTS-1:0] shifted_out;
    logic                   key_synced;

    reset_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_reset_sync (
        .clk     (clk),
        .rst     (reset),
        .sync_rst(rst_int)
    );

    // Releasing the next bit is a left shift: the zeros grow up from bit 0.
    assign shifted_out = reset_out_reg << 1;
    assign key_synced  = key_sync_reg[SYNC_STAGES-1];

    // Synchronise and debounce the key; register a one-cycle request from a
    // debounced press or a software pulse (coincident ones merge into one).
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            key_sync_reg <= '1;
            key_deb_reg  <= 1'b1;
            deb_cnt_reg  <= '0;
            req_reg      <= 1'b0;
        end else begin
            key_sync_reg <= {key_sync_reg[SYNC_STAGES-2:0], key_n};
            req_reg      <= sw_req;
            if (key_synced == key_deb_reg) begin
                deb_cnt_reg <= '0;
            end else if (deb_cnt_reg == DEB_W'(DEB_LAST)) begin
                deb_cnt_reg <= '0;
                key_deb_reg <= key_synced;
                if (!key_synced) begin
                    req_reg <= 1'b1;
                end
            end else begin
                deb_cnt_reg <= deb_cnt_reg + 1'b1;
            end
        end
    end

    // Sequencing FSM with registered outputs; a request overrides any release.
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            state_reg     <= ASSERT;
            hold_cnt_reg  <= '0;
            stag_cnt_reg  <= '0;
            reset_out_reg <= '1;
            ready_reg     <= 1'b0;
            event_cnt_reg <= '0;
        end else if (req_reg) begin
            state_reg     <= ASSERT;
            hold_cnt_reg  <= '0;
            stag_cnt_reg  <= '0;
            reset_out_reg <= '1;
            ready_reg     <= 1'b0;
            if (event_cnt_reg != '1) begin
                event_cnt_reg <= event_cnt_reg + 1'b1;
            end
        end else begin
            case (state_reg)
                ASSERT: begin
                    if (!key_deb_reg) begin
                        hold_cnt_reg <= '0;
                    end else if (hold_cnt_reg == HOLD_W'(HOLD_LAST)) begin
                        if (ONE_SHOT) begin
                            reset_out_reg <= '0;
                            ready_reg     <= 1'b1;
                            state_reg     <= RUN;
                        end else begin
                            reset_out_reg <= shifted_out;
                            stag_cnt_reg  <= '0;
                            state_reg     <= RELEASE;
                        end
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    end
                end
                RELEASE: begin
                    if (stag_cnt_reg == STAG_W'(STAG_LAST)) begin
                        stag_cnt_reg  <= '0;
                        reset_out_reg <= shifted_out;
                        if (shifted_out == '0) begin
                            ready_reg <= 1'b1;
                            state_reg <= RUN;
                        end
                    end else begin
                        stag_cnt_reg <= stag_cnt_reg + 1'b1;
                    end
                end
                RUN: begin
                    reset_out_reg <= '0;
                end
                default: begin
                    state_reg <= ASSERT;
                end
            endcase
        end
    end

    assign reset_out   = reset_out_reg;
    assign ready       = ready_reg;
    assign event_count = event_cnt_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomised bench for reset_sequencer. The reference model expresses each
// output bit as a release time: bit i is low once the current edge reaches
// anchor + HOLD + i*STAGGER, where anchor is the last edge on which the hold
// period restarted (internal reset, request, or key still held down).
module tb_reset_sequencer;

    localparam int N = 4;
    localparam int H = 16;
    localparam int G = 8;
    localparam int S = 2;
    localparam int D = 4;

    logic         clk    = 1'b0;
    logic         reset  = 1'b1;
    logic         key_n  = 1'b1;
    logic         sw_req = 1'b0;
    logic [N-1:0] reset_out;
    logic         ready;
    logic [7:0]   event_count;

    logic         n1_out;
    logic         n1_ready;
    logic [7:0]   n1_cnt;
    logic [N-1:0] s0_out;
    logic         s0_ready;
    logic [7:0]   s0_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int fail_prints = 0;

    // Reference model state.
    int   n        = 0;
    int   sinc     = 0;
    int   anchor   = 0;
    int   evt      = 0;
    int   run      = 0;
    logic deb      = 1'b1;
    logic req_pend = 1'b0;
    logic key_q[$];

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_OUTPUTS(N), .HOLD_CYCLES(H), .STAGGER_CYCLES(G),
        .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk), .reset(reset), .key_n(key_n), .sw_req(sw_req),
        .reset_out(reset_out), .ready(ready), .event_count(event_count)
    );

    reset_sequencer #(
        .NUM_OUTPUTS(1), .HOLD_CYCLES(H), .STAGGER_CYCLES(G),
        .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)
    ) dut_n1 (
        .clk(clk), .reset(reset), .key_n(1'b1), .sw_req(1'b0),
        .reset_out(n1_out), .ready(n1_ready), .event_count(n1_cnt)
    );

    reset_sequencer #(
        .NUM_OUTPUTS(N), .HOLD_CYCLES(H), .STAGGER_CYCLES(0),
        .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)
    ) dut_s0 (
        .clk(clk), .reset(reset), .key_n(1'b1), .sw_req(1'b0),
        .reset_out(s0_out), .ready(s0_ready), .event_count(s0_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (fail_prints < 40) begin
                fail_prints++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
            end
        end
    endtask

    // Advance to the falling edge following relative edge e after reset release.
    task automatic wait_rel(input int e);
        int guard = 0;
        while (sinc != e && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (sinc != e) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_rel: edge %0d never reached, at %0d", e, sinc);
        end
    endtask

    // Reference model, advanced on every rising edge.
    initial begin : model
        logic synced;
        logic press;
        forever begin
            @(posedge clk);
            n++;
            if (reset) sinc = 0;
            else sinc++;
            if (reset || sinc <= S) begin
                anchor   = n;
                evt      = 0;
                deb      = 1'b1;
                run      = 0;
                req_pend = 1'b0;
                key_q.delete();
                for (int i = 0; i < S; i++) key_q.push_back(1'b1);
            end else begin
                // Key level seen by the debouncer is the pin S edges ago.
                synced = key_q.pop_front();
                key_q.push_back(key_n);
                if (req_pend || !deb) anchor = n;
                if (req_pend && evt < 255) evt++;
                press = 1'b0;
                if (synced == deb) begin
                    run = 0;
                end else begin
                    run++;
                    if (run == D) begin
                        deb   = synced;
                        run   = 0;
                        press = !synced;
                    end
                end
                req_pend = sw_req || press;
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    initial begin : compare
        logic [N-1:0] exp_out;
        forever begin
            @(negedge clk);
            if (n > 0) begin
                for (int i = 0; i < N; i++) exp_out[i] = (n < anchor + H + i * G);
                if (reset) exp_out = '1;
                check("model_reset_out", reset_out, exp_out);
                check("model_ready", ready, (exp_out == '0));
                check("model_event_count", event_count, reset ? 0 : evt);
            end
        end
    end

    initial begin : stim
        int k, k2, r, e1, run_left;
        @(negedge clk);
        repeat (3) @(negedge clk);
        check("in_reset_out", reset_out, 4'hF);
        check("in_reset_ready", ready, 0);
        check("in_reset_cnt", event_count, 0);
        reset = 1'b0;

        // Power-on sequence
        wait_rel(17);
        check("po17_out", reset_out, 4'b1111);
        check("n1_17_out", n1_out, 1);
        check("s0_17_out", s0_out, 4'b1111);
        wait_rel(18);
        check("po18_out", reset_out, 4'b1110);
        check("n1_18_out", n1_out, 0);
        check("n1_18_ready", n1_ready, 1);
        check("s0_18_out", s0_out, 4'b0000);
        check("s0_18_ready", s0_ready, 1);
        check("s0_18_cnt", s0_cnt, 0);
        check("n1_18_cnt", n1_cnt, 0);
        wait_rel(26); check("po26_out", reset_out, 4'b1100);
        wait_rel(34); check("po34_out", reset_out, 4'b1000);
        wait_rel(41); check("po41_ready", ready, 0);
        wait_rel(42);
        check("po42_out", reset_out, 4'b0000);
        check("po42_ready", ready, 1);
        check("po42_cnt", event_count, 0);
        wait_rel(50);

        // Software request in RUN
        k = sinc + 1; sw_req = 1'b1; @(negedge clk); sw_req = 1'b0;
        wait_rel(k + 1);
        check("sw_out", reset_out, 4'hF);
        check("sw_ready", ready, 0);
        check("sw_cnt", event_count, 1);
        wait_rel(k + 16); check("sw_hold_out", reset_out, 4'hF);
        wait_rel(k + 17); check("sw_rel0_out", reset_out, 4'hE);
        wait_rel(k + 60);

        // Short bounces: no event
        repeat (3) begin
            key_n = 1'b0; repeat (3) @(negedge clk);
            key_n = 1'b1; repeat (6) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check("bounce_cnt", event_count, 1);
        check("bounce_out", reset_out, 4'h0);

        // Long press holds outputs asserted
        key_n = 1'b0; repeat (30) @(negedge clk);
        check("press_out", reset_out, 4'hF);
        check("press_cnt", event_count, 2);
        repeat (20) @(negedge clk);
        r = sinc + 1; key_n = 1'b1;
        wait_rel(r + 20); check("keyrel_hold_out", reset_out, 4'hF);
        wait_rel(r + 21); check("keyrel_rel0_out", reset_out, 4'hE);
        wait_rel(r + 60);
        check("keyrel_ready", ready, 1);
        check("keyrel_cnt", event_count, 2);

        // Request during RELEASE restarts the sequence
        k = sinc + 1; sw_req = 1'b1; @(negedge clk); sw_req = 1'b0;
        wait_rel(k + 26); check("mid_rel_out", reset_out, 4'b1100);
        k2 = sinc + 1; sw_req = 1'b1; @(negedge clk); sw_req = 1'b0;
        wait_rel(k2 + 1);
        check("restart_out", reset_out, 4'hF);
        check("restart_cnt", event_count, 4);
        wait_rel(k2 + 17); check("restart_rel0_out", reset_out, 4'hE);

        // Key press and sw_req on the same cycle count once
        e1 = sinc + 1; key_n = 1'b0;
        repeat (5) @(negedge clk);
        sw_req = 1'b1; @(negedge clk); sw_req = 1'b0;
        wait_rel(e1 + 6);
        check("coinc_out", reset_out, 4'hF);
        check("coinc_cnt", event_count, 5);
        repeat (10) @(negedge clk);
        key_n = 1'b1;
        repeat (70) @(negedge clk);
        check("coinc_ready", ready, 1);
        check("coinc_cnt_after", event_count, 5);

        // Board reset pulsed mid-RELEASE
        k = sinc + 1; sw_req = 1'b1; @(negedge clk); sw_req = 1'b0;
        wait_rel(k + 20);
        check("prerst_out", reset_out, 4'hE);
        check("prerst_cnt", event_count, 6);
        #3 reset = 1'b1;
        #1;
        check("async_out", reset_out, 4'hF);
        check("async_ready", ready, 0);
        check("async_cnt", event_count, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        wait_rel(17); check("re17_out", reset_out, 4'hF);
        wait_rel(18); check("re18_out", reset_out, 4'hE);
        wait_rel(42);
        check("re42_out", reset_out, 4'h0);
        check("re42_ready", ready, 1);

        // Randomised traffic against the model
        run_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (run_left == 0) begin
                run_left = $urandom_range(1, 12);
                key_n = ($urandom_range(0, 2) != 0);
            end
            run_left--;
            sw_req = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 999) < 2) begin
                #3 reset = 1'b1;
                @(negedge clk); @(negedge clk);
                reset = 1'b0;
            end
            @(negedge clk);
        end
        key_n = 1'b1; sw_req = 1'b0;
        repeat (20) @(negedge clk);

        // Event counter saturation
        repeat (260) begin
            sw_req = 1'b1; @(negedge clk);
            sw_req = 1'b0; @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("sat_cnt", event_count, 255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
